conv_mac_row: RTL and testbench
===============================

Name: conv_mac_row

Overview:
- Downstream consumer of the weight buffer: a signed multiply-accumulate stage that forms one kernel-row dot product.
- Each beat pairs one streamed weight with one activation. After kernel_size beats it emits one fixed-point result, rescaled and saturated to DATA_WIDTH, through a ready/valid output.
- Sits between the weight buffer / activation line feed and the PE output collector.

Parameters:
- DATA_WIDTH, 16: width of weights, activations and the saturated result (signed two's complement).
- ACC_WIDTH, 40: accumulator width. Must be >= 2*DATA_WIDTH+8.
- FRAC_BITS, 8: fractional bits of the operand format. The result is acc arithmetically shifted right by FRAC_BITS.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a dot product. Honoured only in IDLE.
- kernel_size  in  8  number of beats K. Sampled on an accepted start.
- in_valid  in  1  weight/activation pair valid. Driven from the weight buffer's read-valid qualified with activation availability.
- in_ready  out  1  block accepts a pair this cycle.
- w_data  in  DATA_WIDTH  signed weight.
- act_data  in  DATA_WIDTH  signed activation.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_WIDTH  saturated, rescaled result.
- out_acc  out  ACC_WIDTH  raw accumulator, for debug/verification.
- out_sat  out  1  out_data was clamped.
- busy  out  1  state != IDLE.

Behaviour:
- Reset, asynchronous, active-high. Effective immediately, including mid-operation; any partial sum is discarded.
  - State returns to IDLE. Counter, K register, product register, product-valid, accumulator and all outputs go to 0 (in_ready=0, out_valid=0, busy=0).
- States: IDLE, ACCUM, DRAIN, HOLD.
- IDLE:
  - in_ready=0.
  - start=1 with kernel_size!=0: latch K, clear acc, cnt=0, go to ACCUM.
  - start with kernel_size==0: ignored, stay IDLE.
- ACCUM:
  - in_ready=1.
  - On a beat (in_valid & in_ready): prod_q <= w_data*act_data (full 2*DATA_WIDTH signed), prod_v<=1, cnt<=cnt+1.
  - When the beat has cnt==K-1: go to DRAIN.
  - Beats with in_valid=0 are stalls: prod_v<=0, cnt holds.
- Accumulate rule, every state: if prod_v then acc <= acc + sign-extended prod_q. This is 1-cycle pipelined behind the multiply register.
- DRAIN:
  - in_ready=0; the final product is added this cycle; go to HOLD.
- HOLD:
  - out_valid=1. out_data, out_acc and out_sat are registered and stable until the handshake.
  - out_valid & out_ready: go to IDLE, out_valid=0 next cycle.
- Latency: last beat accepted at cycle t → out_valid=1 at t+2 (K=1 included).
- Minimum period with out_ready=1 is K+3 cycles from start to the next accepted start.
- Rescale: s = acc >>> FRAC_BITS (arithmetic).
  - If s > 2^(DATA_WIDTH-1)-1: out_data = max, out_sat=1.
  - If s < -2^(DATA_WIDTH-1): out_data = min, out_sat=1.
  - Otherwise out_data = s[DATA_WIDTH-1:0], out_sat=0.
- No accumulator wrap within spec: ACC_WIDTH guarantees this for K<=255.
- start while busy: ignored, with no effect on the current operation.
- in_valid in IDLE/DRAIN/HOLD: ignored, not consumed (in_ready=0).
- kernel_size changes after start: no effect, because K is latched.
- start in the same cycle as the HOLD→IDLE handshake: ignored. start is evaluated only when the current state is IDLE.

Decomposition:
- Shared package conv_pkg:
  - state enum (IDLE/ACCUM/DRAIN/HOLD).
  - DATA_WIDTH/ACC_WIDTH/FRAC_BITS defaults.
  - saturation min/max constants as functions of width.
- One natural sub-module: sat_rescale, a purely combinational shift and clamp from ACC_WIDTH to DATA_WIDTH with a sat flag. It is instantiated once, ahead of the HOLD output registers.

Test Plan:
1. Reset, then start K=3 with pairs (1.0,2.0), (0.5,4.0), (-1.0,1.0) in Q8.8 (0x0100·0x0200, 0x0080·0x0400, 0xFF00·0x0100), in_valid continuous → out_valid at t+2 after the 3rd beat, out_data=0x0300 (3.0), out_sat=0, busy falls after the handshake.
2. K=1, w=0x0200, act=0x0300 → out_valid exactly 2 cycles after the single beat, out_data=0x0600.
3. K=4, in_valid low on cycles 2 and 3 of ACCUM, out_ready held low 5 cycles → result unchanged and stable through HOLD, in_ready=0 throughout, a start during HOLD is ignored, out_valid drops the cycle after out_ready=1.
4. K=2, pairs 0x7FFF·0x7FFF twice → out_sat=1, out_data=0x7FFF. With 0x8000·0x7FFF twice → out_data=0x8000, out_sat=1.
5. Assert rst mid-ACCUM (after 2 of 5 beats) → same-cycle async clear of busy/in_ready/out_valid. A new start K=2 with 0x0100·0x0100 twice → 0x0200, with no residue from the aborted sum.
6. start with kernel_size=0 → stays IDLE, busy=0, in_ready=0, no out_valid over 10 cycles.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution row multiply-accumulate stage.
package conv_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ACC_WIDTH_DEF  = 40;
    localparam int FRAC_BITS_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Largest positive two's complement value of the given width, zero-extended to 64 bits.
    function automatic logic [63:0] sat_max(input int unsigned width);
        return (64'd1 << (width - 32'd1)) - 64'd1;
    endfunction

    // Most negative value of the given width; only the low 'width' bits are meaningful.
    function automatic logic [63:0] sat_min(input int unsigned width);
        return ~sat_max(width);
    endfunction

endpackage

// File: rtl/conv_mac_row_if.sv
// Operand stream in and result stream out of the row MAC, both ready/valid.
interface conv_mac_row_if
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic [DATA_WIDTH-1:0] act_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ACC_WIDTH-1:0]  out_acc;
    logic                  out_sat;

    modport master (
        output in_valid, w_data, act_data, out_ready,
        input  in_ready, out_valid, out_data, out_acc, out_sat
    );

    modport slave (
        input  in_valid, w_data, act_data, out_ready,
        output in_ready, out_valid, out_data, out_acc, out_sat
    );
endinterface

// File: rtl/conv_mac_row_sat_rescale.sv
// Combinational fixed-point rescale: arithmetic shift of the accumulator, then clamp to DATA_WIDTH.
module sat_rescale
    import conv_pkg::*;
#(
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  sat
);
    localparam logic [DATA_WIDTH-1:0] MAX_C = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] MIN_C = DATA_WIDTH'(sat_min(DATA_WIDTH));

    logic signed [ACC_WIDTH-1:0]    shifted_s;
    logic [ACC_WIDTH-DATA_WIDTH:0]  top_s;

    // The value fits when every bit from the result sign upward agrees.
    always_comb begin
        shifted_s = $signed(acc) >>> FRAC_BITS;
        top_s     = shifted_s[ACC_WIDTH-1:DATA_WIDTH-1];
        if ((&top_s) || (~|top_s)) begin
            data = shifted_s[DATA_WIDTH-1:0];
            sat  = 1'b0;
        end else if (top_s[ACC_WIDTH-DATA_WIDTH]) begin
            data = MIN_C;
            sat  = 1'b1;
        end else begin
            data = MAX_C;
            sat  = 1'b1;
        end
    end
endmodule

// File: rtl/conv_mac_row.sv
// Signed kernel-row dot product: K multiply beats, one-cycle pipelined accumulate,
// rescaled and saturated result held until the downstream handshake.
module conv_mac_row
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       kernel_size,
    output logic             busy,
    conv_mac_row_if.slave    io
);
    localparam int PW = 2 * DATA_WIDTH;

    state_e                 state_q, state_d;
    logic [7:0]             k_q, k_d;
    logic [7:0]             cnt_q, cnt_d;
    logic signed [PW-1:0]   prod_q, prod_d;
    logic                   prod_v_q, prod_v_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [ACC_WIDTH-1:0]   out_acc_q, out_acc_d;
    logic                   out_sat_q, out_sat_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;

    logic signed [PW-1:0]   w_ext_s, act_ext_s;
    logic [ACC_WIDTH-1:0]   acc_sum_s;
    logic [DATA_WIDTH-1:0]  sat_data_s;
    logic                   sat_flag_s;

    // The accumulator always trails the product register by one cycle, in every state.
    always_comb begin
        w_ext_s   = {{DATA_WIDTH{io.w_data[DATA_WIDTH-1]}}, io.w_data};
        act_ext_s = {{DATA_WIDTH{io.act_data[DATA_WIDTH-1]}}, io.act_data};
        if (prod_v_q) begin
            acc_sum_s = acc_q + {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};
        end else begin
            acc_sum_s = acc_q;
        end
    end

    sat_rescale #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_sat_rescale (
        .acc  (acc_sum_s),
        .data (sat_data_s),
        .sat  (sat_flag_s)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        prod_d     = prod_q;
        prod_v_d   = 1'b0;
        acc_d      = acc_sum_s;
        out_data_d = out_data_q;
        out_acc_d  = out_acc_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (kernel_size != 8'd0)) begin
                    k_d     = kernel_size;
                    cnt_d   = 8'd0;
                    acc_d   = '0;
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (io.in_valid) begin
                    prod_d   = w_ext_s * act_ext_s;
                    prod_v_d = 1'b1;
                    cnt_d    = cnt_q + 8'd1;
                    if (cnt_q == (k_q - 8'd1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    prod_v_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                // acc_sum_s already includes the final product here.
                out_data_d = sat_data_s;
                out_acc_d  = acc_sum_s;
                out_sat_d  = sat_flag_s;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (io.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_HOLD);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= 8'd0;
            cnt_q       <= 8'd0;
            prod_q      <= '0;
            prod_v_q    <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_acc_q   <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            prod_v_q    <= prod_v_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_acc_q   <= out_acc_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_acc   = out_acc_q;
    assign io.out_sat   = out_sat_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_conv_mac_row.sv
// Directed bench for conv_mac_row: a per-cycle reference model plus literal result checks.
module tb_conv_mac_row;
    import conv_pkg::*;

    localparam int DW = 16;
    localparam int AW = 40;
    localparam int FB = 8;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] kernel_size;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    conv_mac_row_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) io ();

    conv_mac_row #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .FRAC_BITS  (FB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .kernel_size (kernel_size),
        .busy        (busy),
        .io          (io)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result from the exact integer dot product.
    function automatic logic [DW-1:0] m_data(input longint acc);
        longint s;
        s = acc >>> FB;
        if (s > 64'sd32767) return 16'h7FFF;
        else if (s < -64'sd32768) return 16'h8000;
        else return s[15:0];
    endfunction

    function automatic logic m_sat(input longint acc);
        longint s;
        s = acc >>> FB;
        return (s > 64'sd32767) || (s < -64'sd32768);
    endfunction

    typedef enum int {M_IDLE, M_ACC, M_DRAIN, M_HOLD} mphase_e;
    mphase_e mph     = M_IDLE;
    int      m_k     = 0;
    int      m_beats = 0;
    longint  m_sum   = 0;

    // Reference model: compare this cycle's outputs, then advance on the inputs seen at the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", io.in_ready, 64'd0);
            chk("rst_busy", busy, 64'd0);
            chk("rst_out_valid", io.out_valid, 64'd0);
            mph   = M_IDLE;
            m_sum = 0;
        end else begin
            chk("m_in_ready", io.in_ready, (mph == M_ACC));
            chk("m_busy", busy, (mph != M_IDLE));
            chk("m_out_valid", io.out_valid, (mph == M_HOLD));
            if (mph == M_HOLD) begin
                chk("m_out_data", io.out_data, m_data(m_sum));
                chk("m_out_sat", io.out_sat, m_sat(m_sum));
                chk("m_out_acc", io.out_acc, {24'd0, m_sum[39:0]});
            end
            case (mph)
                M_IDLE: if (start && (kernel_size != 8'd0)) begin
                    m_k     = kernel_size;
                    m_beats = 0;
                    m_sum   = 0;
                    mph     = M_ACC;
                end
                M_ACC: if (io.in_valid) begin
                    m_sum += longint'($signed(io.w_data)) * longint'($signed(io.act_data));
                    m_beats++;
                    if (m_beats == m_k) mph = M_DRAIN;
                end
                M_DRAIN: mph = M_HOLD;
                M_HOLD: if (io.out_ready) mph = M_IDLE;
                default: mph = M_IDLE;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] k);
        start       = 1'b1;
        kernel_size = k;
        step();
        start       = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] w, input logic [DW-1:0] a);
        io.in_valid = 1'b1;
        io.w_data   = w;
        io.act_data = a;
        step();
        io.in_valid = 1'b0;
    endtask

    task automatic stall();
        io.in_valid = 1'b0;
        step();
    endtask

    // Called right after the last beat; returns the number of cycles until out_valid.
    task automatic wait_out(input string nm, output int cyc);
        cyc = 0;
        while (!io.out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        if (cyc >= 20) chk({nm, "_timeout"}, 64'd0, 64'd1);
    endtask

    int lat;

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        kernel_size = 8'd0;
        io.in_valid = 1'b0;
        io.w_data   = '0;
        io.act_data = '0;
        io.out_ready = 1'b1;
        step();
        step();
        chk("reset_busy", busy, 64'd0);
        chk("reset_in_ready", io.in_ready, 64'd0);
        chk("reset_out_valid", io.out_valid, 64'd0);
        chk("reset_out_acc", io.out_acc, 64'd0);
        rst = 1'b0;
        step();

        // 1: 1.0*2.0 + 0.5*4.0 - 1.0*1.0 = 3.0; kernel_size changed after start must not matter
        do_start(8'd3);
        kernel_size = 8'd255;
        beat(16'h0100, 16'h0200);
        beat(16'h0080, 16'h0400);
        beat(16'hFF00, 16'h0100);
        wait_out("t1", lat);
        chk("t1_latency", lat, 64'd1);
        chk("t1_data", io.out_data, 64'h0300);
        chk("t1_sat", io.out_sat, 64'd0);
        step();
        chk("t1_busy_after", busy, 64'd0);
        chk("t1_valid_after", io.out_valid, 64'd0);

        // 2: single beat
        do_start(8'd1);
        beat(16'h0200, 16'h0300);
        wait_out("t2", lat);
        chk("t2_latency", lat, 64'd1);
        chk("t2_data", io.out_data, 64'h0600);
        step();

        // 3: stalls, back-pressure, ignored start and in_valid during HOLD
        io.out_ready = 1'b0;
        do_start(8'd4);
        beat(16'h0100, 16'h0100);
        stall();
        stall();
        beat(16'h0200, 16'h0080);
        beat(16'hFF80, 16'h0200);
        beat(16'h0040, 16'h0400);
        wait_out("t3", lat);
        chk("t3_latency", lat, 64'd1);
        for (int i = 0; i < 5; i++) begin
            io.in_valid = 1'b1;
            if (i == 2) begin
                start       = 1'b1;
                kernel_size = 8'd2;
            end
            step();
            start = 1'b0;
            chk("t3_hold_data", io.out_data, 64'h0200);
            chk("t3_hold_valid", io.out_valid, 64'd1);
            chk("t3_hold_in_ready", io.in_ready, 64'd0);
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        step();
        chk("t3_valid_drop", io.out_valid, 64'd0);
        chk("t3_busy_drop", busy, 64'd0);

        // 4: positive and negative saturation
        do_start(8'd2);
        beat(16'h7FFF, 16'h7FFF);
        beat(16'h7FFF, 16'h7FFF);
        wait_out("t4a", lat);
        chk("t4a_data", io.out_data, 64'h7FFF);
        chk("t4a_sat", io.out_sat, 64'd1);
        step();
        do_start(8'd2);
        beat(16'h8000, 16'h7FFF);
        beat(16'h8000, 16'h7FFF);
        wait_out("t4b", lat);
        chk("t4b_data", io.out_data, 64'h8000);
        chk("t4b_sat", io.out_sat, 64'd1);
        step();

        // 5: reset mid-ACCUM, then a clean run
        do_start(8'd5);
        beat(16'h1234, 16'h0567);
        beat(16'h0F00, 16'h0300);
        io.in_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 64'd0);
        chk("t5_rst_in_ready", io.in_ready, 64'd0);
        chk("t5_rst_out_valid", io.out_valid, 64'd0);
        chk("t5_rst_out_acc", io.out_acc, 64'd0);
        io.in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        do_start(8'd2);
        beat(16'h0100, 16'h0100);
        beat(16'h0100, 16'h0100);
        wait_out("t5", lat);
        chk("t5_data", io.out_data, 64'h0200);
        chk("t5_acc", io.out_acc, 64'h20000);
        step();

        // 6: zero-length start is ignored
        do_start(8'd0);
        for (int i = 0; i < 10; i++) begin
            io.in_valid = 1'b1;
            step();
            chk("t6_busy", busy, 64'd0);
            chk("t6_in_ready", io.in_ready, 64'd0);
            chk("t6_out_valid", io.out_valid, 64'd0);
        end
        io.in_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
